// File: rtl/sort_pkg.sv
// Shared types and elaboration helpers for the shear-sort engine.
// The SORT_SIGNED_EN macro (see sort_cas) selects signed key comparison.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    ROW_PH,
    COL_PH,
    DONE
  } state_t;

  // Row/column phase pairs repeated ceil(log2 rows) times, plus a closing row phase.
  function automatic int phase_count(input int rows);
    return 2 * $clog2(rows) + 1;
  endfunction

  function automatic int step_width(input int rows, input int cols);
    int m;
    m = (rows > cols) ? rows : cols;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sort_cas.sv
// Compare-and-swap cell: the lo-side output takes the key that belongs at the lower index.
// Defining SORT_SIGNED_EN compares keys as two's-complement values.
module sort_cas
  import sort_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             descending_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic a_gt_b;
  logic a_lt_b;
  logic swap;

`ifdef SORT_SIGNED_EN
  assign a_gt_b = $signed(a_i) > $signed(b_i);
  assign a_lt_b = $signed(a_i) < $signed(b_i);
`else
  assign a_gt_b = a_i > b_i;
  assign a_lt_b = a_i < b_i;
`endif

  // Strict comparisons keep equal keys in place.
  assign swap = descending_i ? a_lt_b : a_gt_b;
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort.sv
// Mesh shear-sort: loads a ROW x COL grid once, then sorts it into snake order with
// alternating row/column odd-even transposition phases. SORT_SIGNED_EN selects signed keys.
module sort
  import sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROW   = 8,
  parameter int COL   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH*COL*ROW-1:0] init_values,
  output logic [WIDTH*COL*ROW-1:0] sorted_values,
  output logic                     done
);

  localparam int NPH    = phase_count(ROW);
  localparam int PH_W   = $clog2(NPH) + 1;
  localparam int STEP_W = step_width(ROW, COL);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                done_q;

  logic [WIDTH-1:0] grid_q [ROW][COL];
  logic [WIDTH-1:0] grid_d [ROW][COL];

  logic [WIDTH-1:0] row_lo [ROW][COL-1];
  logic [WIDTH-1:0] row_hi [ROW][COL-1];
  logic [WIDTH-1:0] col_lo [ROW-1][COL];
  logic [WIDTH-1:0] col_hi [ROW-1][COL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      phase_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    case (state_q)
      LOAD: begin
        state_d = ROW_PH;
        phase_d = '0;
        step_d  = '0;
      end
      ROW_PH: begin
        if (step_q == STEP_W'(COL - 1)) begin
          step_d = '0;
          if (phase_q == PH_W'(NPH - 1)) begin
            state_d = DONE;
          end else begin
            state_d = COL_PH;
            phase_d = phase_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      COL_PH: begin
        if (step_q == STEP_W'(ROW - 1)) begin
          step_d  = '0;
          state_d = ROW_PH;
          phase_d = phase_q + 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // done lags the DONE state by one edge so it rises one clock after the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else if (state_q == DONE) begin
      done_q <= 1'b1;
    end
  end

  assign done = done_q;

  generate
    for (genvar gi = 0; gi < ROW; gi++) begin : g_row_cas
      for (genvar gj = 0; gj < COL - 1; gj++) begin : g_cell
        sort_cas #(.WIDTH(WIDTH)) u_cas (
          .a_i          (grid_q[gi][gj]),
          .b_i          (grid_q[gi][gj+1]),
          .descending_i (1'(gi % 2)),
          .lo_o         (row_lo[gi][gj]),
          .hi_o         (row_hi[gi][gj])
        );
      end
    end

    for (genvar gi = 0; gi < ROW - 1; gi++) begin : g_col_cas
      for (genvar gj = 0; gj < COL; gj++) begin : g_cell
        sort_cas #(.WIDTH(WIDTH)) u_cas (
          .a_i          (grid_q[gi][gj]),
          .b_i          (grid_q[gi+1][gj]),
          .descending_i (1'b0),
          .lo_o         (col_lo[gi][gj]),
          .hi_o         (col_hi[gi][gj])
        );
      end
    end

    for (genvar gi = 0; gi < ROW; gi++) begin : g_grid_row
      for (genvar gj = 0; gj < COL; gj++) begin : g_grid_col
        localparam logic JPAR = 1'(gj % 2);
        localparam logic IPAR = 1'(gi % 2);
        logic [WIDTH-1:0] row_v;
        logic [WIDTH-1:0] col_v;

        // An element pairs rightward when its index parity matches the step parity.
        if (gj == 0) begin : g_rfirst
          assign row_v = (step_q[0] == JPAR) ? row_lo[gi][gj] : grid_q[gi][gj];
        end else if (gj == COL - 1) begin : g_rlast
          assign row_v = (step_q[0] != JPAR) ? row_hi[gi][gj-1] : grid_q[gi][gj];
        end else begin : g_rmid
          assign row_v = (step_q[0] == JPAR) ? row_lo[gi][gj] : row_hi[gi][gj-1];
        end

        if (gi == 0) begin : g_cfirst
          assign col_v = (step_q[0] == IPAR) ? col_lo[gi][gj] : grid_q[gi][gj];
        end else if (gi == ROW - 1) begin : g_clast
          assign col_v = (step_q[0] != IPAR) ? col_hi[gi-1][gj] : grid_q[gi][gj];
        end else begin : g_cmid
          assign col_v = (step_q[0] == IPAR) ? col_lo[gi][gj] : col_hi[gi-1][gj];
        end

        assign grid_d[gi][gj] =
          (state_q == LOAD)   ? init_values[(gi*COL+gj)*WIDTH +: WIDTH] :
          (state_q == ROW_PH) ? row_v :
          (state_q == COL_PH) ? col_v : grid_q[gi][gj];

        assign sorted_values[(gi*COL+gj)*WIDTH +: WIDTH] = grid_q[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROW; i++) begin
        for (int j = 0; j < COL; j++) begin
          grid_q[i][j] <= '0;
        end
      end
    end else begin
      grid_q <= grid_d;
    end
  end

endmodule

// File: tb/tb_sort.sv
// Self-checking bench for the shear-sort engine: random and directed grids compared
// against a plain full sort laid out in snake order.
module tb_sort;

  localparam int W = 8;
  localparam int R = 8;
  localparam int C = 8;
  localparam int N = R * C;
  localparam int DONE_EDGE = 58;
  localparam int EDGE_LIMIT = 300;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] init_values = '0;
  logic [N*W-1:0] sorted_values;
  logic           done;

  int checks = 0;
  int passed = 0;

  sort #(.WIDTH(W), .ROW(R), .COL(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .init_values   (init_values),
    .sorted_values (sorted_values),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic int key_val(input logic [W-1:0] k);
    int v;
`ifdef SORT_SIGNED_EN
    v = $signed(k);
`else
    v = int'(k);
`endif
    return v;
  endfunction

  // Reference: sort all keys, then lay them out row by row, reversing odd rows.
  function automatic logic [N*W-1:0] model(input logic [N*W-1:0] g);
    int q[$];
    logic [N*W-1:0] r;
    int i;
    int col;
    for (int k = 0; k < N; k++) q.push_back(key_val(g[k*W +: W]));
    q.sort();
    r = '0;
    for (int k = 0; k < N; k++) begin
      i = k / C;
      col = (i % 2 == 0) ? (k % C) : (C - 1 - (k % C));
      r[(i*C+col)*W +: W] = W'(q[k]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] get(input logic [N*W-1:0] g, input int i, input int j);
    return g[(i*C+j)*W +: W];
  endfunction

  function automatic logic [N*W-1:0] rand_grid(input int maxv);
    logic [N*W-1:0] g;
    for (int k = 0; k < N; k++) g[k*W +: W] = W'($urandom_range(0, maxv));
    return g;
  endfunction

  task automatic start_sort(input logic [N*W-1:0] g);
    rst = 1'b0;
    init_values = g;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_done(inout int edges);
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < EDGE_LIMIT);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    init_values = rand_grid(255);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sorted_values !== '0) $display("FAIL reset_grid got=%h want=0", sorted_values);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done);
    else passed++;
    $display("reset: grid and done held low");
  endtask

  task automatic test_sort(input string name, input logic [N*W-1:0] g);
    int edges;
    logic [N*W-1:0] exp;
    exp = model(g);
    edges = 0;
    start_sort(g);
    wait_done(edges);
    $display("%s: done after %0d edges", name, edges);
    checks++;
    if (edges != DONE_EDGE) $display("FAIL %s_latency got=%0d want=%0d", name, edges, DONE_EDGE);
    else passed++;
    checks++;
    if (sorted_values !== exp) $display("FAIL %s_grid got=%h want=%h", name, sorted_values, exp);
    else passed++;
  endtask

  task automatic test_uniform();
    logic [N*W-1:0] g;
    for (int k = 0; k < N; k++) g[k*W +: W] = 8'd5;
    test_sort("uniform", g);
    checks++;
    if (sorted_values !== g) $display("FAIL uniform_unchanged got=%h want=%h", sorted_values, g);
    else passed++;
  endtask

  task automatic test_reverse();
    logic [N*W-1:0] g;
    for (int k = 0; k < N; k++) g[k*W +: W] = W'(63 - k);
    test_sort("reverse", g);
    checks++;
    if (get(sorted_values, 0, 0) !== 8'd0)
      $display("FAIL reverse_00 got=%0d want=0", get(sorted_values, 0, 0));
    else passed++;
    checks++;
    if (get(sorted_values, 7, 0) !== 8'd63)
      $display("FAIL reverse_70 got=%0d want=63", get(sorted_values, 7, 0));
    else passed++;
  endtask

  task automatic test_mixed();
    logic [N*W-1:0] g;
    int row0[8] = '{0, 12, 4, 9, 50, 3, 12, 19};
    g = rand_grid(99);
    for (int j = 0; j < C; j++) g[j*W +: W] = W'(row0[j]);
    g[(5*C+3)*W +: W] = 8'd99;
    test_sort("mixed", g);
    checks++;
    if (get(sorted_values, 0, 0) !== 8'd0)
      $display("FAIL mixed_00 got=%0d want=0", get(sorted_values, 0, 0));
    else passed++;
    checks++;
    if (get(sorted_values, 7, 0) !== 8'd99)
      $display("FAIL mixed_70 got=%0d want=99", get(sorted_values, 7, 0));
    else passed++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) test_sort("random", rand_grid(255));
    test_sort("dups", rand_grid(3));
  endtask

  task automatic test_mid_reset();
    int edges;
    logic [N*W-1:0] g;
    g = rand_grid(255);
    edges = 0;
    start_sort(g);
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (sorted_values !== '0) $display("FAIL midreset_grid got=%h want=0", sorted_values);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL midreset_done got=%b want=0", done);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    wait_done(edges);
    $display("midreset: done after %0d edges", edges);
    checks++;
    if (edges != DONE_EDGE) $display("FAIL midreset_latency got=%0d want=%0d", edges, DONE_EDGE);
    else passed++;
    checks++;
    if (sorted_values !== model(g)) $display("FAIL midreset_grid_final got=%h want=%h", sorted_values, model(g));
    else passed++;
  endtask

  task automatic test_init_change();
    int edges;
    logic [N*W-1:0] g;
    logic [N*W-1:0] exp;
    g = rand_grid(200);
    exp = model(g);
    edges = 0;
    start_sort(g);
    @(posedge clk);
    #1;
    edges = 1;
    init_values = '1;
    wait_done(edges);
    $display("initchange: done after %0d edges", edges);
    checks++;
    if (edges != DONE_EDGE) $display("FAIL initchange_latency got=%0d want=%0d", edges, DONE_EDGE);
    else passed++;
    checks++;
    if (sorted_values !== exp) $display("FAIL initchange_grid got=%h want=%h", sorted_values, exp);
    else passed++;
    init_values = rand_grid(255);
    repeat (10) @(posedge clk);
    #1;
    $display("hold: 10 edges after done");
    checks++;
    if (done !== 1'b1) $display("FAIL hold_done got=%b want=1", done);
    else passed++;
    checks++;
    if (sorted_values !== exp) $display("FAIL hold_grid got=%h want=%h", sorted_values, exp);
    else passed++;
  endtask

  task automatic test_sign_boundary();
    logic [N*W-1:0] g;
    g = '0;
    g[(3*C+4)*W +: W] = 8'h80;
    g[(1*C+1)*W +: W] = 8'h7F;
    test_sort("sign", g);
    checks++;
`ifdef SORT_SIGNED_EN
    if (get(sorted_values, 0, 0) !== 8'h80)
      $display("FAIL sign_pos got=%h want=80 at (0,0)", get(sorted_values, 0, 0));
    else passed++;
`else
    if (get(sorted_values, 7, 0) !== 8'h80)
      $display("FAIL sign_pos got=%h want=80 at (7,0)", get(sorted_values, 7, 0));
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_reverse();
    test_mixed();
    test_random();
    test_mid_reset();
    test_init_change();
    test_sign_boundary();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
